gnrc_stream_wrr_pkt_arbiter: RTL and testbench

Packet-aware weighted round-robin arbiter that decides which of N input streams owns a shared stream bus, e.g. the mux stage of the stream share bus.
- Holds a grant for a whole packet, from the first beat through the handshake of the beat with last set.
- Serves each input up to a runtime-programmable number of consecutive packets before rotating priority.
- Drives the select of a downstream stream mux and observes the muxed output handshake.

---
 rtl/gnrc_arb_pkg.sv | 14 +
 rtl/gnrc_rr_pick.sv | 33 +++
 rtl/gnrc_stream_wrr_pkt_arbiter.sv | 133 +++++++++++++
 tb/tb_gnrc_stream_wrr_pkt_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gnrc_arb_pkg.sv
// Shared types and sizing helpers for the generic stream arbiters.
package gnrc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int arb_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gnrc_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping circularly through all N inputs.
module gnrc_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = ID_W'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    onehot = '0;
    if (any) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/gnrc_stream_wrr_pkt_arbiter.sv
// Packet-aware weighted round-robin arbiter: holds a grant for a whole packet
// and serves each input up to its programmed number of packets per turn.
module gnrc_stream_wrr_pkt_arbiter
  import gnrc_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = arb_id_w(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          last_i,
  input  logic [N*WEIGHT_W-1:0] weight_i,
  input  logic                  ready_i,
  output logic [N-1:0]          gnt_o,
  output logic                  gnt_valid_o,
  output logic [ID_W-1:0]       gnt_id_o,
  output logic                  locked_o
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;

  logic [N-1:0]        pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  logic [WEIGHT_W-1:0] weight_arr [N];
  logic [WEIGHT_W-1:0] w_sel, w_eff, cnt_inc, c_new;
  logic [ID_W-1:0]     ptr_after;
  logic                xfer, pend;

  for (genvar gi = 0; gi < N; gi++) begin : g_weight
    assign weight_arr[gi] = weight_i[gi*WEIGHT_W +: WEIGHT_W];
  end

  gnrc_rr_pick #(
    .N   (N),
    .ID_W(ID_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant depends only on state and requests, never on ready_i.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    locked_o    = 1'b0;
    if (state_q == LOCKED) begin
      gnt_o[lock_id_q] = 1'b1;
      gnt_id_o         = lock_id_q;
      gnt_valid_o      = req_i[lock_id_q];
      locked_o         = 1'b1;
    end else if (pick_any) begin
      gnt_o       = pick_onehot;
      gnt_id_o    = pick_idx;
      gnt_valid_o = 1'b1;
    end
  end

  assign xfer = gnt_valid_o & ready_i;
  assign pend = xfer & last_i[gnt_id_o];

  // Quantum bookkeeping for whichever input is currently granted.
  always_comb begin
    w_sel     = weight_arr[gnt_id_o];
    w_eff     = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + WEIGHT_W'(1);
    c_new     = (gnt_id_o == ptr_q) ? cnt_inc : WEIGHT_W'(1);
    ptr_after = (gnt_id_o == ID_W'(N - 1)) ? '0 : gnt_id_o + ID_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    lock_id_d = lock_id_q;
    if (flush_i) begin
      state_d   = IDLE;
      ptr_d     = '0;
      cnt_d     = '0;
      lock_id_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer && !pend) begin
            state_d   = LOCKED;
            lock_id_d = gnt_id_o;
          end
        end
        LOCKED: begin
          if (pend) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (pend) begin
        if (c_new >= w_eff) begin
          ptr_d = ptr_after;
          cnt_d = '0;
        end else begin
          ptr_d = gnt_id_o;
          cnt_d = c_new;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_gnrc_stream_wrr_pkt_arbiter.sv
// Scoreboard bench for the packet-aware WRR arbiter: a behavioural model
// predicts each cycle's grant outputs, which are compared mid-cycle.
module tb_gnrc_stream_wrr_pkt_arbiter;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int IDW = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i;
  logic [N-1:0]   req_i;
  logic [N-1:0]   last_i;
  logic [N*WW-1:0] weight_i;
  logic           ready_i;
  logic [N-1:0]   gnt_o;
  logic           gnt_valid_o;
  logic [IDW-1:0] gnt_id_o;
  logic           locked_o;

  gnrc_stream_wrr_pkt_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .req_i      (req_i),
    .last_i     (last_i),
    .weight_i   (weight_i),
    .ready_i    (ready_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_id_o   (gnt_id_o),
    .locked_o   (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic           valid;
    logic [IDW-1:0] id;
    logic           locked;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_locked = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  int m_lock   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (m_locked != 0) begin
      e.gnt[m_lock] = 1'b1;
      e.id          = IDW'(m_lock);
      e.valid       = req_i[m_lock];
      e.locked      = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req_i[j] && !e.valid) begin
          e.gnt[j] = 1'b1;
          e.id     = IDW'(j);
          e.valid  = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic model_quantum(input int s);
    int w, c;
    w = int'(weight_i[s*WW +: WW]);
    if (w == 0) w = 1;
    if (s == m_ptr) c = (m_cnt == 15) ? 15 : m_cnt + 1;
    else c = 1;
    if (c >= w) begin
      m_ptr = (s + 1) % N;
      m_cnt = 0;
    end else begin
      m_ptr = s;
      m_cnt = c;
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_ptr    = 0;
    m_cnt    = 0;
    m_lock   = 0;
  endtask

  task automatic model_update();
    exp_t e;
    logic xfer, lst;
    if (flush_i) begin
      model_reset();
    end else begin
      e    = model_out();
      xfer = e.valid & ready_i;
      lst  = last_i[e.id];
      if (xfer && lst) begin
        m_locked = 0;
        model_quantum(int'(e.id));
      end else if (xfer && m_locked == 0) begin
        m_locked = 1;
        m_lock   = int'(e.id);
      end
    end
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic rd, input logic fl);
    exp_t e;
    req_i   = r;
    last_i  = l;
    ready_i = rd;
    flush_i = fl;
    sb_q.push_back(model_out());
    @(negedge clk_i);
    e = sb_q.pop_front();
    $display("%s: req=%b last=%b rdy=%b fl=%b -> gnt=%b v=%b id=%0d lk=%b", tag, r, l, rd,
             fl, gnt_o, gnt_valid_o, gnt_id_o, locked_o);
    check_eq({tag, ".gnt"}, 32'(gnt_o), 32'(e.gnt));
    check_eq({tag, ".valid"}, 32'(gnt_valid_o), 32'(e.valid));
    check_eq({tag, ".id"}, 32'(gnt_id_o), 32'(e.id));
    check_eq({tag, ".locked"}, 32'(locked_o), 32'(e.locked));
    check_eq({tag, ".onehot0"}, 32'($onehot0(gnt_o)), 32'd1);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    req_i    = '0;
    last_i   = '0;
    ready_i  = 1'b0;
    weight_i = 16'h1111;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset.gnt", 32'(gnt_o), 32'd0);
    check_eq("reset.valid", 32'(gnt_valid_o), 32'd0);
    check_eq("reset.id", 32'(gnt_id_o), 32'd0);
    check_eq("reset.locked", 32'(locked_o), 32'd0);
    rst_ni = 1'b1;

    // Equal weights, single-beat packets: 0,1,2,3,0
    for (int i = 0; i < 5; i++) step("rr", 4'b1111, 4'b1111, 1'b1, 1'b0);

    // Weight 3 on input 0: 0,0,0,1,0,0,0,1
    weight_i = 16'h1113;
    step("flush0", 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("wrr", 4'b0011, 4'b0011, 1'b1, 1'b0);

    // Multi-beat packet on input 2 with stalls and a valid gap
    weight_i = 16'h1111;
    step("pkt.b1wait", 4'b0101, 4'b0000, 1'b0, 1'b0);
    step("pkt.b1", 4'b0101, 4'b0000, 1'b1, 1'b0);
    step("pkt.gap", 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("pkt.b2", 4'b0101, 4'b0000, 1'b1, 1'b0);
    step("pkt.stall", 4'b0101, 4'b0000, 1'b0, 1'b0);
    step("pkt.b3", 4'b0101, 4'b0000, 1'b1, 1'b0);
    step("pkt.b4last", 4'b0101, 4'b0100, 1'b1, 1'b0);
    step("pkt.next", 4'b0001, 4'b0001, 1'b1, 1'b0);

    // Weight 0 behaves as 1: pointer moves past input 1 after each packet
    weight_i = 16'h1101;
    for (int i = 0; i < 3; i++) step("w0", 4'b0010, 4'b0010, 1'b1, 1'b0);
    step("w0.ptr", 4'b1011, 4'b0000, 1'b0, 1'b0);

    // Flush while locked on input 3
    weight_i = 16'h1111;
    step("fl.lock3", 4'b1000, 4'b0000, 1'b1, 1'b0);
    step("fl.flush", 4'b1001, 4'b0000, 1'b1, 1'b1);
    step("fl.after", 4'b1001, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset mid-packet
    step("ar.lock2", 4'b0100, 4'b0000, 1'b1, 1'b0);
    req_i   = 4'b0001;
    ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst.gnt", 32'(gnt_o), 32'b0001);
    check_eq("async_rst.id", 32'(gnt_id_o), 32'd0);
    check_eq("async_rst.locked", 32'(locked_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) step("ar.rr", 4'b1111, 4'b1111, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
